// File: rtl/fma_path_merge.sv
// rtl/fma_path_merge.sv - in-order merge of FMA near/far path results via a tag FIFO
// Optional per-path result counters: define FMA_PATH_MERGE_STATS_EN.
module fma_path_merge #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_path,
  output logic                     issue_ready,
  input  logic                     near_valid,
  input  logic [DATA_W-1:0]        near_data,
  output logic                     near_ready,
  input  logic                     far_valid,
  input  logic [DATA_W-1:0]        far_data,
  output logic                     far_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_path,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   inflight
`ifdef FMA_PATH_MERGE_STATS_EN
  ,
  output logic [15:0]              near_cnt,
  output logic [15:0]              far_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0] tag_mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      inflight_nxt;
  logic             head_tag;
  logic             out_free;
  logic             take_near;
  logic             take_far;
  logic             push;
  logic             pop;

  assign head_tag   = tag_mem[rd_ptr];
  assign out_free   = !out_valid || out_ready;
  assign near_ready = (inflight != '0) && head_tag && out_free;
  assign far_ready  = (inflight != '0) && !head_tag && out_free;
  assign take_near  = near_valid && near_ready;
  assign take_far   = far_valid && far_ready;
  assign pop        = take_near || take_far;
  assign push       = issue_valid && issue_ready;

  always_comb begin
    inflight_nxt = inflight;
    if (push && !pop) begin
      inflight_nxt = inflight + CNT_ONE;
    end else if (pop && !push) begin
      inflight_nxt = inflight - CNT_ONE;
    end
  end

  // Tag storage needs no reset: entries are only read once counted in inflight.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= issue_path;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= '0;
      issue_ready <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_path    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      inflight    <= inflight_nxt;
      issue_ready <= (inflight_nxt != FULL_CNT);
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= take_near ? near_data : far_data;
        out_path  <= take_near;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FMA_PATH_MERGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      near_cnt <= '0;
      far_cnt  <= '0;
    end else begin
      if (take_near && near_cnt != 16'hFFFF) begin
        near_cnt <= near_cnt + 16'd1;
      end
      if (take_far && far_cnt != 16'hFFFF) begin
        far_cnt <= far_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fma_path_merge.md
Name: fma_path_merge

Overview:
- Consumer side of the FMA near/far path decision. At issue, records each operation's path_sel (1 = near path, 0 = far path) in a tag FIFO.
- Accepts results from the near-path and far-path datapaths, which have different latencies, and returns them strictly in issue order on a single valid/ready output.
- Sits between the two FMA path datapaths and the writeback stage.

Parameters:
- DATA_W, 32, result width in bits.
- DEPTH, 8, max in-flight operations (tag FIFO entries); power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  operation issued this cycle
- issue_path  input  1  path decision for the issued op: 1 = near, 0 = far
- issue_ready  output  1  tag FIFO not full
- near_valid  input  1  near-path result available
- near_data  input  DATA_W  near-path result
- near_ready  output  1  near result accepted this cycle
- far_valid  input  1  far-path result available
- far_data  input  DATA_W  far-path result
- far_ready  output  1  far result accepted this cycle
- out_valid  output  1  merged result valid
- out_data  output  DATA_W  merged result
- out_path  output  1  path that produced out_data
- out_ready  input  1  downstream accepts
- inflight  output  clog2(DEPTH)+1  number of tags held in the FIFO

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: FIFO empty, inflight=0, out_valid=0, out_data=0, out_path=0. issue_ready=1 in the cycle after reset.
- Reset mid-operation drops all tags and the output register. Any results still arriving afterwards see an empty FIFO, so near_ready and far_ready stay 0 for them.
- Tag FIFO:
  - Circular buffer with wr_ptr and rd_ptr of clog2(DEPTH) bits each, wrapping from DEPTH-1 to 0. Occupancy counter is inflight.
  - issue_ready = (inflight != DEPTH). This is registered state, not a combinational function of pop.
  - Push when issue_valid && issue_ready. When full, a push is refused even if a pop happens in the same cycle.
- Output register:
  - out_free = !out_valid || out_ready.
  - near_ready = (inflight != 0) && head_tag==1 && out_free.
  - far_ready = (inflight != 0) && head_tag==0 && out_free.
  - The two readys are mutually exclusive. A result on the path not selected by the head tag stalls (ready=0) until its turn.
- Transfer: when near_valid&&near_ready or far_valid&&far_ready:
  - Load out_data and out_path from the accepted source and set out_valid=1 on the next edge.
  - Pop the head tag.
- out_valid clears when out_ready=1 and no new transfer occurs in that cycle.
- Latency: 1 cycle from an accepted input to out_valid. Full throughput is one result per cycle when out_ready stays high.
- Simultaneous push and pop: inflight is unchanged and both pointers advance.
  - Push into an empty FIFO: the tag becomes visible as head on the next cycle (no same-cycle bypass).
- A valid result with an empty FIFO is ignored (ready=0). Behaviour is undefined only if upstream produces results with no matching issue.
- Output is stable while out_valid && !out_ready.

Optional Feature:
- Macro FMA_PATH_MERGE_STATS_EN.
- When defined, adds two output ports: near_cnt [15:0] and far_cnt [15:0].
  - Each counts accepted near or far results respectively.
  - Both are saturating at 16'hFFFF and cleared by rst.
- When undefined, these ports and counters are absent. Core behaviour is identical either way.

Test Plan:
- Reset then issue paths 1,0,1. Far result 0xBBBB arrives first, then near 0xAAAA, then near 0xCCCC. Required: far_ready stays 0 until 0xAAAA is accepted. Output order is 0xAAAA(path 1), 0xBBBB(path 0), 0xCCCC(path 1), each 1 cycle after acceptance.
- Issue 8 ops with DEPTH=8. Required: issue_ready=0 and inflight=8. A 9th issue_valid is not pushed, even in the same cycle as a pop. inflight=7 after the pop, and issue_ready returns to 1.
- Hold out_ready=0 with out_valid=1 while the next near result is valid. Required: near_ready=0, out_data is held. Raise out_ready: the next result loads in the same cycle, with no bubble.
- Stream 20 ops alternating paths, with results matching order and out_ready=1 throughout. Required: one output per cycle, pointers wrap past 7->0, and all 20 outputs come out in order.
- Assert rst with 3 tags in flight and out_valid=1. Required: next cycle out_valid=0, inflight=0, issue_ready=1, and a late near_valid sees near_ready=0.
- With FMA_PATH_MERGE_STATS_EN defined, run 5 near and 3 far results. Required: near_cnt=5 and far_cnt=3; both reach 0 after rst.
